// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap generator at the MEM/WB boundary.
// Drives the trap code plus mepc/mtvec to the pipeline controller and commits
// trap/mret state on the redirect edge.
// Optional feature macro: CSR_MCYCLE_EN adds the 64-bit mcycle/mcycleh counter.
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        ecall_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mtvec_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  localparam logic [31:0] EXC_IRQ   = 32'h1;
  localparam logic [31:0] EXC_ECALL = 32'h8;
  localparam logic [31:0] EXC_ILL   = 32'ha;
  localparam logic [31:0] EXC_MRET  = 32'he;

  // Bits a CSR write may change; zero for read-only and unmapped addresses.
  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      A_MSTATUS:  wmask = 32'h0000_0088;
      A_MIE:      wmask = 32'h0000_0880;
      A_MTVEC:    wmask = 32'hFFFF_FFFF;
      A_MSCRATCH: wmask = 32'hFFFF_FFFF;
      A_MEPC:     wmask = 32'hFFFF_FFFC;
      A_MCAUSE:   wmask = 32'hFFFF_FFFF;
`ifdef CSR_MCYCLE_EN
      A_MCYCLE:   wmask = 32'hFFFF_FFFF;
      A_MCYCLEH:  wmask = 32'hFFFF_FFFF;
`endif
      default:    wmask = 32'h0;
    endcase
  endfunction

  // Only addresses that actually hold writable state take part in forwarding.
  function automatic logic writable(input logic [11:0] a);
    writable = (wmask(a) != 32'h0);
  endfunction

  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic        mtie_q, mtie_d;
  logic        meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [1:0]  tsync_q, esync_q;
`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic        cyc_wr;
`endif

  logic mtip, meip, irq, ext_pend;
  logic [31:0] rd_raw;

  assign mtip     = tsync_q[1];
  assign meip     = esync_q[1];
  assign ext_pend = meip & meie_q;
  assign irq      = mst_mie_q & (ext_pend | (mtip & mtie_q));

  assign csr_mepc_o  = (csr_we_i && csr_waddr_i == A_MEPC)  ? (csr_wdata_i & 32'hFFFF_FFFC) : mepc_q;
  assign csr_mtvec_o = (csr_we_i && csr_waddr_i == A_MTVEC) ? csr_wdata_i : mtvec_q;

  // Prioritized trap code for the MEM-stage instruction.
  always_comb begin
    excepttype_o = 32'h0;
    if (mem_valid_i) begin
      if (irq)            excepttype_o = EXC_IRQ;
      else if (illegal_i) excepttype_o = EXC_ILL;
      else if (ecall_i)   excepttype_o = EXC_ECALL;
      else if (mret_i)    excepttype_o = EXC_MRET;
    end
  end

  // CSR read mux with same-cycle write forwarding.
  always_comb begin
    rd_raw = 32'h0;
    case (csr_raddr_i)
      A_MSTATUS:  rd_raw = {24'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      A_MIE:      rd_raw = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
      A_MTVEC:    rd_raw = mtvec_q;
      A_MSCRATCH: rd_raw = mscratch_q;
      A_MEPC:     rd_raw = mepc_q;
      A_MCAUSE:   rd_raw = mcause_q;
      A_MIP:      rd_raw = {20'b0, meip, 3'b0, mtip, 7'b0};
`ifdef CSR_MCYCLE_EN
      A_MCYCLE:   rd_raw = mcycle_q[31:0];
      A_MCYCLEH:  rd_raw = mcycle_q[63:32];
`endif
      default:    rd_raw = 32'h0;
    endcase
    csr_rdata_o = rd_raw;
    if (csr_we_i && csr_waddr_i == csr_raddr_i && writable(csr_waddr_i))
      csr_rdata_o = csr_wdata_i & wmask(csr_waddr_i);
  end

  // Next state: CSR write first, then trap/mret overrides the fields it owns.
  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mtie_d     = mtie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef CSR_MCYCLE_EN
    mcycle_d   = mcycle_q;
    cyc_wr     = 1'b0;
`endif
    if (csr_we_i) begin
      case (csr_waddr_i)
        A_MSTATUS: begin
          mst_mie_d  = csr_wdata_i[3];
          mst_mpie_d = csr_wdata_i[7];
        end
        A_MIE: begin
          mtie_d = csr_wdata_i[7];
          meie_d = csr_wdata_i[11];
        end
        A_MTVEC:    mtvec_d    = csr_wdata_i;
        A_MSCRATCH: mscratch_d = csr_wdata_i;
        A_MEPC:     mepc_d     = csr_wdata_i & 32'hFFFF_FFFC;
        A_MCAUSE:   mcause_d   = csr_wdata_i;
`ifdef CSR_MCYCLE_EN
        A_MCYCLE: begin
          mcycle_d[31:0] = csr_wdata_i;
          cyc_wr         = 1'b1;
        end
        A_MCYCLEH: begin
          mcycle_d[63:32] = csr_wdata_i;
          cyc_wr          = 1'b1;
        end
`endif
        default: ;
      endcase
    end
`ifdef CSR_MCYCLE_EN
    if (!cyc_wr) mcycle_d = mcycle_q + 64'd1;
`endif
    case (excepttype_o)
      EXC_IRQ, EXC_ILL, EXC_ECALL: begin
        mepc_d     = mem_pc_i & 32'hFFFF_FFFC;
        mst_mpie_d = mst_mie_q;
        mst_mie_d  = 1'b0;
        if (excepttype_o == EXC_IRQ)
          mcause_d = ext_pend ? 32'h8000_000b : 32'h8000_0007;
        else if (excepttype_o == EXC_ILL)
          mcause_d = 32'd2;
        else
          mcause_d = 32'd11;
      end
      EXC_MRET: begin
        mst_mie_d  = mst_mpie_q;
        mst_mpie_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers and interrupt synchronizers; reset overrides any commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      tsync_q    <= 2'b00;
      esync_q    <= 2'b00;
`ifdef CSR_MCYCLE_EN
      mcycle_q   <= 64'h0;
`endif
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mtie_q     <= mtie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      tsync_q    <= {tsync_q[0], timer_irq_i};
      esync_q    <= {esync_q[0], ext_irq_i};
`ifdef CSR_MCYCLE_EN
      mcycle_q   <= mcycle_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Testbench for csr_trap_unit: directed scenarios plus randomized traffic,
// all checked against an address-indexed behavioural CSR model.
module tb_csr_trap_unit;
  localparam logic [31:0] RST_VEC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        ecall, illegal, mret;
  logic        timer_irq, ext_irq;
  logic        csr_we;
  logic [11:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata, excepttype, csr_mepc, csr_mtvec;

  csr_trap_unit #(.RESET_MTVEC(RST_VEC)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc),
    .ecall_i(ecall), .illegal_i(illegal), .mret_i(mret),
    .timer_irq_i(timer_irq), .ext_irq_i(ext_irq),
    .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
    .csr_raddr_i(csr_raddr), .csr_rdata_o(csr_rdata),
    .excepttype_o(excepttype), .csr_mepc_o(csr_mepc), .csr_mtvec_o(csr_mtvec)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_csr [int];   // architectural CSR contents keyed by address
  logic [63:0] ref_cycle;
  bit          t_seen1, t_seen2, e_seen1, e_seen2;  // line as seen one / two edges ago

  function automatic logic [31:0] mask_of(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h0000_0880;
      12'h341: return 32'hFFFF_FFFC;
      12'h305, 12'h340, 12'h342: return 32'hFFFF_FFFF;
`ifdef CSR_MCYCLE_EN
      12'hB00, 12'hB80: return 32'hFFFF_FFFF;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [11:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == 12'h344) begin
      v[7]  = t_seen2;
      v[11] = e_seen2;
      return v;
    end
`ifdef CSR_MCYCLE_EN
    if (a == 12'hB00) return ref_cycle[31:0];
    if (a == 12'hB80) return ref_cycle[63:32];
`endif
    if (ref_csr.exists(int'(a))) return ref_csr[int'(a)];
    return 32'h0;
  endfunction

  function automatic logic [31:0] fwd_model(input logic [11:0] a);
    if (csr_we && csr_waddr == a && mask_of(a) != 0) return csr_wdata & mask_of(a);
    return rd_model(a);
  endfunction

  function automatic logic [31:0] exp_exc();
    logic [31:0] ms, ie, ip;
    bit irq;
    ms = rd_model(12'h300);
    ie = rd_model(12'h304);
    ip = rd_model(12'h344);
    irq = ms[3] && ((ip[11] && ie[11]) || (ip[7] && ie[7]));
    if (!mem_valid) return 32'h0;
    if (irq)     return 32'h1;
    if (illegal) return 32'ha;
    if (ecall)   return 32'h8;
    if (mret)    return 32'he;
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] exc, ms, ie, ip;
    bit cyc_written;
    exc = exp_exc();
    ms = rd_model(12'h300);
    ie = rd_model(12'h304);
    ip = rd_model(12'h344);
    if (rst) begin
      ref_csr.delete();
      ref_csr[32'h300] = 0; ref_csr[32'h304] = 0; ref_csr[32'h340] = 0;
      ref_csr[32'h341] = 0; ref_csr[32'h342] = 0; ref_csr[32'h305] = RST_VEC;
      ref_cycle = 0;
      t_seen1 = 0; t_seen2 = 0; e_seen1 = 0; e_seen2 = 0;
      return;
    end
    cyc_written = 0;
    if (csr_we && mask_of(csr_waddr) != 0) begin
      if (csr_waddr == 12'hB00) begin
        ref_cycle[31:0] = csr_wdata; cyc_written = 1;
      end else if (csr_waddr == 12'hB80) begin
        ref_cycle[63:32] = csr_wdata; cyc_written = 1;
      end else begin
        ref_csr[int'(csr_waddr)] = csr_wdata & mask_of(csr_waddr);
      end
    end
    if (!cyc_written) ref_cycle = ref_cycle + 1;
    if (exc == 32'h1 || exc == 32'h8 || exc == 32'ha) begin
      ref_csr[32'h341] = mem_pc & 32'hFFFF_FFFC;
      ref_csr[32'h300] = ms[3] ? 32'h80 : 32'h0;
      if (exc == 32'h1)      ref_csr[32'h342] = (ip[11] && ie[11]) ? 32'h8000_000b : 32'h8000_0007;
      else if (exc == 32'ha) ref_csr[32'h342] = 32'd2;
      else                   ref_csr[32'h342] = 32'd11;
    end else if (exc == 32'he) begin
      ref_csr[32'h300] = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
    end
    t_seen2 = t_seen1; t_seen1 = timer_irq;
    e_seen2 = e_seen1; e_seen1 = ext_irq;
  endtask

  // One clock cycle: inputs are set at the falling edge before the call.
  task automatic step(input bit chk = 1'b1);
    #1;
    if (chk) begin
      check("exc",   excepttype, exp_exc());
      check("rdata", csr_rdata,  fwd_model(csr_raddr));
      check("mepc",  csr_mepc,   fwd_model(12'h341));
      check("mtvec", csr_mtvec,  fwd_model(12'h305));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    mem_valid = 0; ecall = 0; illegal = 0; mret = 0; csr_we = 0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    idle();
    csr_we = 1; csr_waddr = a; csr_wdata = d;
    step();
    csr_we = 0;
  endtask

  task automatic peek(input logic [11:0] a, input string tag, input logic [31:0] e);
    csr_raddr = a;
    #1;
    check(tag, csr_rdata, e);
  endtask

  logic [11:0] addr_pool [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h344, 12'hB00, 12'hB80, 12'h123, 12'h7C0};

  initial begin
    bit seen;
    rst = 1; timer_irq = 0; ext_irq = 0; mem_pc = 0;
    csr_raddr = 0; csr_waddr = 0; csr_wdata = 0;
    idle();
    @(negedge clk);
    step(0);
    step(0);
    rst = 0;

    // Reset state of every address in the pool
    check("rst_exc", excepttype, 32'h0);
    check("rst_mtvec", csr_mtvec, RST_VEC);
    check("rst_mepc", csr_mepc, 32'h0);
    foreach (addr_pool[i]) begin
      csr_raddr = addr_pool[i];
      step();
    end
`ifndef CSR_MCYCLE_EN
    peek(12'hB00, "no_mcycle", 32'h0);
    step();
`endif

    // ecall with MIE set
    wr(12'h300, 32'h8);
    mem_valid = 1; ecall = 1; mem_pc = 32'h104;
    #1 check("ecall_exc", excepttype, 32'h8);
    step();
    idle();
    peek(12'h341, "ecall_mepc", 32'h104);   step();
    peek(12'h342, "ecall_mcause", 32'd11);  step();
    peek(12'h300, "ecall_mstatus", 32'h80); step();

    // illegal beats ecall
    mem_valid = 1; ecall = 1; illegal = 1; mem_pc = 32'h108;
    #1 check("prio_exc", excepttype, 32'ha);
    step();
    idle();
    peek(12'h342, "ill_mcause", 32'd2); step();

    // Timer interrupt through the synchronizer
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    timer_irq = 1; mem_valid = 1; mem_pc = 32'h200;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      #1 if (excepttype == 32'h1) seen = 1;
      step();
    end
    check("tmr_within3", 32'(seen), 32'h1);
    idle();
    peek(12'h342, "tmr_mcause", 32'h8000_0007); step();
    peek(12'h341, "tmr_mepc", 32'h200);         step();
    mem_valid = 1; mret = 1;
    #1 check("mret_exc", excepttype, 32'he);
    check("mret_mepc_out", csr_mepc, 32'h200);
    step();
    idle();
    peek(12'h300, "mret_mstatus", 32'h88); step();
    mem_valid = 1; mem_pc = 32'h220;
    #1 check("retrap_exc", excepttype, 32'h1);
    step();
    idle(); timer_irq = 0;

    // Pending external interrupt held off by bubbles
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h880);
    ext_irq = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("bubble_exc", excepttype, 32'h0);
      step();
    end
    peek(12'h344, "mip_meip", 32'h800);
    step();
    mem_valid = 1; mem_pc = 32'h300;
    #1 check("first_valid_exc", excepttype, 32'h1);
    step();
    idle(); ext_irq = 0;
    peek(12'h342, "ext_mcause", 32'h8000_000b); step();
    step(); step();

    // Same-cycle mepc write alongside mret is forwarded and kept
    mem_valid = 1; mret = 1; csr_we = 1; csr_waddr = 12'h341; csr_wdata = 32'h300;
    #1 check("mret_fwd_mepc", csr_mepc, 32'h300);
    step();
    idle();
    peek(12'h341, "mret_mepc_kept", 32'h300); step();

    // Trap owns mepc; mscratch write in the trap cycle survives
    mem_valid = 1; ecall = 1; mem_pc = 32'h400; csr_we = 1; csr_waddr = 12'h341; csr_wdata = 32'h500;
    step();
    idle();
    peek(12'h341, "trap_mepc_wins", 32'h400); step();
    mem_valid = 1; ecall = 1; mem_pc = 32'h404; csr_we = 1; csr_waddr = 12'h340; csr_wdata = 32'hCAFE;
    step();
    idle();
    peek(12'h340, "trap_mscratch", 32'hCAFE); step();

`ifdef CSR_MCYCLE_EN
    wr(12'hB80, 32'h5);
    wr(12'hB00, 32'hFFFF_FFFF);
    peek(12'hB80, "mcycleh_before", 32'h5); step();
    peek(12'hB80, "mcycleh_inc", 32'h6);    step();
`endif

    // Reset in the same cycle as a trap
    wr(12'h341, 32'h44);
    mem_valid = 1; ecall = 1; mem_pc = 32'h600; rst = 1;
    step();
    rst = 0; idle();
    peek(12'h341, "rst_wins_mepc", 32'h0); step();
    peek(12'h305, "rst_wins_mtvec", RST_VEC); step();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_pc    = $urandom & 32'hFFFF_FFFC;
      ecall     = ($urandom_range(0, 5) == 0);
      illegal   = ($urandom_range(0, 7) == 0);
      mret      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 19) == 0) ext_irq = ~ext_irq;
      csr_raddr = addr_pool[$urandom_range(0, 10)];
      csr_waddr = addr_pool[$urandom_range(0, 10)];
      csr_wdata = $urandom;
      csr_we    = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      if (csr_waddr == 12'h300 && exp_exc() != 0) csr_we = 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
